// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default widths for the instruction-fetch front end.
//   fetch_state_t : sequencer state encoding (IDLE, FETCH, HOLD, DRAIN)
//   ADDR_W_DEF    : default PC / ROM word-address width
//   DATA_W_DEF    : default instruction width
//   RESET_PC_DEF  : default first fetch address after reset
package fetch_pkg;

  localparam int ADDR_W_DEF   = 6;
  localparam int DATA_W_DEF   = 32;
  localparam int RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // States in which a ROM transaction may be outstanding.
  function automatic logic is_req_state(input fetch_state_t st);
    return (st == FETCH) || (st == DRAIN);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC priority mux.
//   pc                 : current program counter
//   flush, flush_pc    : exception redirect request and target (highest priority)
//   branch_flag,
//   branch_target_addr : taken-branch redirect request and target
//   redirect           : 1 when either redirect source is active
//   pc_next_sel_pc     : flush_pc, else branch_target_addr, else pc+1 (wraps)
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target_addr,
  output logic              redirect,
  output logic [ADDR_W-1:0] pc_next_sel_pc
);

  logic [ADDR_W-1:0] pc_inc;

  // Plain ADDR_W-bit add: the top address rolls over to 0 with no carry out.
  assign pc_inc   = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign redirect = flush | branch_flag;

  always_comb begin
    pc_next_sel_pc = pc_inc;
    if (flush) begin
      pc_next_sel_pc = flush_pc;
    end else if (branch_flag) begin
      pc_next_sel_pc = branch_target_addr;
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: instruction-fetch sequencer. Owns the PC, issues ROM
// requests over a req/ack handshake and holds one fetched instruction for
// decode under a valid/ready handshake.
//   clk, rst           : clock (rising edge), asynchronous active-low reset
//   flush, flush_pc    : exception redirect (beats branch)
//   branch_flag,
//   branch_target_addr : taken-branch redirect
//   stall              : blocks the hand-off to decode only
//   ce                 : ROM enable, low only in IDLE
//   rom_req, rom_addr  : fetch request and address
//   rom_ack, rom_data  : ROM completion and read data
//   inst_valid,
//   inst_ready         : decode handshake
//   inst, inst_pc      : held instruction and its address
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target_addr,
  input  logic              stall,
  output logic              ce,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [DATA_W-1:0] rom_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [DATA_W-1:0] inst_reg, inst_next;
  logic [ADDR_W-1:0] inst_pc_reg, inst_pc_next;
  logic              inst_valid_reg, inst_valid_next;
  // Address of the request being drained: pc already points at the redirect
  // target, but the ROM must keep seeing the old address until it acks.
  logic [ADDR_W-1:0] drain_addr_reg, drain_addr_next;
  // One-cycle request gap after a drained ack, so the ROM sees req drop
  // between the abandoned transaction and the new one.
  logic              gap_reg, gap_next;

  logic              redirect;
  logic [ADDR_W-1:0] sel_pc;
  logic              accept;

  pc_next_sel #(
    .ADDR_W(ADDR_W)
  ) u_pc_next_sel (
    .pc                 (pc_reg),
    .flush              (flush),
    .flush_pc           (flush_pc),
    .branch_flag        (branch_flag),
    .branch_target_addr (branch_target_addr),
    .redirect           (redirect),
    .pc_next_sel_pc     (sel_pc)
  );

  assign accept = inst_valid_reg & inst_ready & ~stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC_W;
      inst_reg       <= '0;
      inst_pc_reg    <= '0;
      inst_valid_reg <= 1'b0;
      drain_addr_reg <= '0;
      gap_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      inst_reg       <= inst_next;
      inst_pc_reg    <= inst_pc_next;
      inst_valid_reg <= inst_valid_next;
      drain_addr_reg <= drain_addr_next;
      gap_reg        <= gap_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    inst_next       = inst_reg;
    inst_pc_next    = inst_pc_reg;
    inst_valid_next = inst_valid_reg;
    drain_addr_next = drain_addr_reg;
    gap_next        = 1'b0;

    case (state_reg)
      IDLE: begin
        state_next = FETCH;
      end

      FETCH: begin
        if (gap_reg) begin
          // No request is on the bus this cycle; a redirect just retargets.
          if (redirect) begin
            pc_next         = sel_pc;
            inst_valid_next = 1'b0;
          end
        end else if (redirect) begin
          pc_next         = sel_pc;
          inst_valid_next = 1'b0;
          if (!rom_ack) begin
            drain_addr_next = pc_reg;
            state_next      = DRAIN;
          end
          // With an ack in the same cycle the data is simply dropped and
          // the next request goes straight out at the target.
        end else if (rom_ack) begin
          inst_next       = rom_data;
          inst_pc_next    = pc_reg;
          inst_valid_next = 1'b1;
          pc_next         = sel_pc;
          state_next      = HOLD;
        end
      end

      HOLD: begin
        if (redirect) begin
          // Redirect drops the held instruction even if decode takes it now.
          pc_next         = sel_pc;
          inst_valid_next = 1'b0;
          state_next      = FETCH;
        end else if (accept) begin
          inst_valid_next = 1'b0;
          state_next      = FETCH;
        end
      end

      DRAIN: begin
        if (redirect) begin
          pc_next         = sel_pc;
          inst_valid_next = 1'b0;
        end
        if (rom_ack) begin
          state_next = FETCH;
          gap_next   = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ce         = (state_reg != IDLE);
  assign rom_req    = is_req_state(state_reg) & ~((state_reg == FETCH) & gap_reg);
  assign rom_addr   = (state_reg == DRAIN) ? drain_addr_reg : pc_reg;
  assign inst_valid = inst_valid_reg;
  assign inst       = inst_reg;
  assign inst_pc    = inst_pc_reg;

endmodule
